// File: rtl/control_sequencer_if.sv
// Instruction/flag inputs and control-word outputs of the microcode sequencer.
// The master side feeds IR and flags; the slave side is the sequencer itself.
interface control_sequencer_if #(
  parameter int IR_WIDTH = 8
);
  logic [IR_WIDTH-1:0] i_ir;
  logic                i_flag_c;
  logic                i_flag_z;
  logic [15:0]         o_ctrl;
  logic [2:0]          o_step;
  logic                o_halted;

  modport master (
    output i_ir, i_flag_c, i_flag_z,
    input  o_ctrl, o_step, o_halted
  );

  modport slave (
    input  i_ir, i_flag_c, i_flag_z,
    output o_ctrl, o_step, o_halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fetch in T0/T1, per-opcode execute in T2..T4,
// with a terminal HALT state left only through reset.
module control_sequencer #(
  parameter int IR_WIDTH = 8
) (
  input  logic                mclk,
  input  logic                i_rst_n,
  input  logic                mclk_en,
  control_sequencer_if.slave  bus
);

  localparam logic [15:0] C_HLT = 16'h0001;
  localparam logic [15:0] C_MI  = 16'h0002;
  localparam logic [15:0] C_RI  = 16'h0004;
  localparam logic [15:0] C_RO  = 16'h0008;
  localparam logic [15:0] C_IO  = 16'h0010;
  localparam logic [15:0] C_II  = 16'h0020;
  localparam logic [15:0] C_AI  = 16'h0040;
  localparam logic [15:0] C_AO  = 16'h0080;
  localparam logic [15:0] C_EO  = 16'h0100;
  localparam logic [15:0] C_SU  = 16'h0200;
  localparam logic [15:0] C_BI  = 16'h0400;
  localparam logic [15:0] C_OI  = 16'h0800;
  localparam logic [15:0] C_CE  = 16'h1000;
  localparam logic [15:0] C_CO  = 16'h2000;
  localparam logic [15:0] C_J   = 16'h4000;
  localparam logic [15:0] C_FI  = 16'h8000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  step, step_nxt;
  logic [3:0]  opcode;
  logic [15:0] ctrl;

  assign opcode = bus.i_ir[IR_WIDTH-1 -: 4];

  // Final microstep of each opcode; anything not listed finishes at T2.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  endfunction

  always_ff @(posedge mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      step  <= 3'd0;
    end else if (mclk_en) begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // HALT freezes step at 2; out-of-range step codes fall back to T0.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    if (state == RUN) begin
      if (step > 3'd4)
        step_nxt = 3'd0;
      else if (step == 3'd2 && opcode == OP_HLT)
        state_nxt = HALT;
      else if (step >= last_step(opcode))
        step_nxt = 3'd0;
      else
        step_nxt = 3'(step + 3'd1);
    end
  end

  // Decoded straight from registered step so loads coincide with the step edge.
  always_comb begin
    ctrl = 16'h0000;
    if (state == HALT) begin
      ctrl = C_HLT;
    end else begin
      case (step)
        3'd0: ctrl = C_CO | C_MI;
        3'd1: ctrl = C_RO | C_II | C_CE;
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = C_IO | C_MI;
            OP_LDI: ctrl = C_IO | C_AI;
            OP_JMP: ctrl = C_IO | C_J;
            OP_JC:  ctrl = bus.i_flag_c ? (C_IO | C_J) : 16'h0000;
            OP_JZ:  ctrl = bus.i_flag_z ? (C_IO | C_J) : 16'h0000;
            OP_OUT: ctrl = C_AO | C_OI;
            OP_HLT: ctrl = C_HLT;
            default: ctrl = 16'h0000;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA:         ctrl = C_RO | C_AI;
            OP_ADD, OP_SUB: ctrl = C_RO | C_BI;
            OP_STA:         ctrl = C_AO | C_RI;
            default:        ctrl = 16'h0000;
          endcase
        end
        3'd4: begin
          case (opcode)
            OP_ADD:  ctrl = C_EO | C_AI | C_FI;
            OP_SUB:  ctrl = C_EO | C_AI | C_SU | C_FI;
            default: ctrl = 16'h0000;
          endcase
        end
        default: ctrl = 16'h0000;
      endcase
    end
  end

  assign bus.o_ctrl   = ctrl;
  assign bus.o_step   = step;
  assign bus.o_halted = (state == HALT);

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 8, instruction register width; opcode = i_ir[IR_WIDTH-1 -: 4].
REQ-002 SHALL provide: mclk  input  1  master clock, all state on posedge.
REQ-003 SHALL provide: i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide: mclk_en  input  1  clock-enable qualifying every state advance.
REQ-005 SHALL provide: i_ir  input  IR_WIDTH  current instruction register contents.
REQ-006 SHALL provide: i_flag_c  input  1  registered carry flag.
REQ-007 SHALL provide: i_flag_z  input  1  registered zero flag.
REQ-008 SHALL provide: o_ctrl  output  16  control word (load/output enables to registers, bus, PC).
REQ-009 SHALL provide: o_step  output  3  current microstep T0..T4.
REQ-010 SHALL provide: o_halted  output  1  high while in HALT state.

Function
REQ-011 o_ctrl bit map SHALL be: 0 HLT, 1 MI, 2 RI, 3 RO, 4 IO, 5 II, 6 AI, 7 AO, 8 EO, 9 SU, 10 BI, 11 OI, 12 CE, 13 CO, 14 J, 15 FI.
REQ-012 o_ctrl SHALL be combinational from registered step, halt state, i_ir opcode and flags; no added latency, so downstream registers load on the same posedge the step advances.
REQ-013 States SHALL be RUN (with step 0..4) and HALT; step and state change only on posedge mclk with mclk_en=1.
REQ-014 Fetch: T0 SHALL drive CO|MI; T1 SHALL drive RO|II|CE, for every opcode.
REQ-015 Execute microcode (T2/T3/T4) SHALL be: LDA 0000: IO|MI / RO|AI; ADD 0001: IO|MI / RO|BI / EO|AI|FI; SUB 0010: IO|MI / RO|BI / EO|AI|SU|FI; STA 0100: IO|MI / AO|RI; LDI 0101: IO|AI; JMP 0110: IO|J; JC 0111: IO|J if i_flag_c else 0; JZ 1000: IO|J if i_flag_z else 0; OUT 1110: AO|OI; HLT 1111: HLT.
REQ-016 Each opcode SHALL end on its last listed step: next enabled edge returns step to T0 (LDA/STA end T3, ADD/SUB end T4, LDI/JMP/JC/JZ/OUT end T2).
REQ-017 Undefined opcodes (0011, 1001-1101) SHALL execute T2 with o_ctrl=0 then return to T0.
REQ-018 JC/JZ SHALL sample flags combinationally during T2; untaken branch SHALL still consume T2.
REQ-019 On enabled edge at T2 with opcode HLT, state SHALL enter HALT; in HALT o_ctrl=16'h0001, o_halted=1, o_step holds 2, and no further transitions occur until reset.
REQ-020 With mclk_en=0, step/state SHALL hold and o_ctrl SHALL remain stable for constant inputs.
REQ-021 i_ir changes during T0/T1 SHALL only affect o_ctrl from T2 onward.
REQ-022 Step counter SHALL never exceed 4; any illegal encoding SHALL recover to T0 on next enabled edge.

Reset
REQ-023 i_rst_n=0 SHALL asynchronously force RUN, step=T0, o_halted=0, independent of mclk/mclk_en.
REQ-024 During reset o_ctrl SHALL equal the T0 word 16'h2002 (CO|MI).
REQ-025 Reset asserted mid-instruction or in HALT SHALL abandon it; first enabled edge after deassertion advances T0->T1.

Verification
REQ-026 Reset, mclk_en=1, i_ir=8'h1E (ADD): o_ctrl sequence 2002, 1028, 0012, 0408, 8140, then 2002; o_step 0,1,2,3,4,0.
REQ-027 i_ir=8'h7x, i_flag_c=0 then 1 on next pass: T2 o_ctrl 0000 then 4010; both return to T0 after T2.
REQ-028 i_ir=8'hF0: after T2 edge o_halted=1, o_ctrl=0001 held for 20 enabled cycles; i_rst_n pulse low -> o_step=0, o_ctrl=2002.
REQ-029 mclk_en toggled 1-of-4 cycles with LDA 8'h0F: each step persists exactly 4 mclk cycles; T3 word 0048.
REQ-030 Assert i_rst_n=0 asynchronously mid-T3 of STA (between edges): o_step=0 and o_ctrl=2002 immediately, before next mclk edge.
REQ-031 i_ir=8'h3x (undefined): T2 o_ctrl=0000, return to T0 after one enabled edge.
